// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl - multi-cycle execute controller in front of a combinational ALU.
//
// Owns the general register file and the 5-bit PSR {N,Z,F,L,C}. Each instruction
// runs IDLE -> DECODE -> EXEC -> WB (4 cycles). In DECODE the instruction is
// turned into the ALU opcode and A/B operands. In EXEC the ALU result and flags
// are captured. In WB Rdest and the PSR are updated.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   instr, instr_valid    instruction in; instr_ready is high only in IDLE
//   ld_en/ld_addr/ld_data register preload, honoured only in IDLE
//   dbg_addr/dbg_data     combinational register read port
//   alu_a/alu_b/alu_opcode/alu_cin   registered operands to the ALU
//   alu_c/alu_flags       ALU result and flags {N,Z,F,L,C}
//   psr                   processor status register
//   done, illegal         one-cycle pulses during WB
module alu_exec_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              ld_en,
  input  logic [3:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [4:0]        alu_flags,
  output logic [4:0]        psr,
  output logic              done,
  output logic              illegal
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [4:0]        psr_q, psr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [7:0]        alu_opcode_q, alu_opcode_d;
  logic              ill_q, ill_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [4:0]        flags_q, flags_d;

  // decode of the latched instruction
  logic [3:0]        op, ext, rdest, rsrc;
  logic [7:0]        dec_opcode;
  logic [DATA_W-1:0] dec_b;
  logic              dec_ill;

  logic              accept, is_nop, is_cmp, wb_write, wb_psr;

  assign op    = instr_q[15:12];
  assign rdest = instr_q[11:8];
  assign ext   = instr_q[7:4];
  assign rsrc  = instr_q[3:0];

  always_comb begin
    dec_opcode = {op, ext};
    dec_b      = rf_q[rsrc];
    dec_ill    = 1'b0;
    case (op)
      4'b0000: begin
        case (ext)
          4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
          4'b0111, 4'b1000, 4'b1001, 4'b1011, 4'b1111: dec_ill = 1'b0;
          // ext=0000 is only the canonical all-zero NOP; a stray Rdest/Rsrc
          // with ext=0000 is treated as an undecodable instruction.
          4'b0000: dec_ill = (instr_q != 16'h0000);
          default: dec_ill = 1'b1;
        endcase
      end
      4'b1000: begin
        if (ext == 4'b0100)
          dec_b = rf_q[rsrc];
        else if (ext[3:1] == 3'b000)
          dec_b = {{(DATA_W-4){1'b0}}, instr_q[3:0]};
        else
          dec_ill = 1'b1;
      end
      4'b0101, 4'b0111, 4'b1001, 4'b1011:
        dec_b = {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]};
      4'b0110, 4'b1101, 4'b1110:
        dec_b = {{(DATA_W-8){1'b0}}, instr_q[7:0]};
      default: dec_ill = 1'b1;
    endcase
  end

  assign accept = (state_q == S_IDLE) && instr_valid;

  // compare-class results only feed the PSR, never a register
  assign is_nop   = (alu_opcode_q == 8'h00);
  assign is_cmp   = (alu_opcode_q == 8'h0B) || (alu_opcode_q == 8'h0F) ||
                    (alu_opcode_q[7:4] == 4'hB) || (alu_opcode_q[7:4] == 4'hE);
  assign wb_psr   = (state_q == S_WB) && !ill_q && !is_nop;
  assign wb_write = wb_psr && !is_cmp;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    psr_d        = psr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    ill_d        = ill_q;
    c_d          = c_q;
    flags_d      = flags_q;
    for (int i = 0; i < NUM_REGS; i++) rf_d[i] = rf_q[i];

    case (state_q)
      S_IDLE: begin
        // preload lands on the accept edge; operands are read a cycle later
        if (ld_en) rf_d[ld_addr] = ld_data;
        if (accept) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_opcode_d = dec_opcode;
        alu_a_d      = rf_q[rdest];
        alu_b_d      = dec_b;
        ill_d        = dec_ill;
        state_d      = S_EXEC;
      end
      S_EXEC: begin
        c_d     = alu_c;
        flags_d = alu_flags;
        state_d = S_WB;
      end
      default: begin
        if (wb_write) rf_d[rdest] = c_q;
        if (wb_psr)   psr_d = flags_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      psr_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      ill_q        <= 1'b0;
      c_q          <= '0;
      flags_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      psr_q        <= psr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      ill_q        <= ill_d;
      c_q          <= c_d;
      flags_q      <= flags_d;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign dbg_data    = rf_q[dbg_addr];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_cin     = psr_q[0];
  assign psr         = psr_q;
  assign done        = (state_q == S_WB);
  assign illegal     = (state_q == S_WB) && ill_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] alu_a, alu_b;
  logic [7:0]  alu_opcode;
  logic        alu_cin;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        done, illegal;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_cin(alu_cin), .alu_c(alu_c), .alu_flags(alu_flags),
    .psr(psr), .done(done), .illegal(illegal)
  );

  // Stand-in ALU covering only the opcodes the vectors use. Anything else
  // returns a poison value so a wrongful write-back or PSR load is visible.
  logic [16:0] m_sum;
  always_comb begin
    m_sum     = '0;
    alu_c     = 16'hDEAD;
    alu_flags = 5'b11111;
    if (alu_opcode == 8'h05 || alu_opcode == 8'h07 || alu_opcode[7:4] == 4'h5) begin
      m_sum = {1'b0, alu_a} + {1'b0, alu_b} +
              ((alu_opcode == 8'h07) ? {16'd0, alu_cin} : 17'd0);
      alu_c = m_sum[15:0];
      alu_flags[4] = m_sum[15];
      alu_flags[3] = (m_sum[15:0] == 16'h0000);
      alu_flags[2] = (alu_a[15] == alu_b[15]) && (m_sum[15] != alu_a[15]);
      alu_flags[1] = 1'b0;
      alu_flags[0] = (alu_opcode[7:4] == 4'h5) ? 1'b0 : m_sum[16];
    end else if (alu_opcode == 8'h0B) begin
      alu_c     = 16'h0000;
      alu_flags = {($signed(alu_a) < $signed(alu_b)), (alu_a == alu_b), 1'b0,
                   (alu_a < alu_b), 1'b0};
    end
  end

  task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Runs one instruction from IDLE back to IDLE, returning what was seen in
  // EXEC (operands) and WB (pulses). Ends on a negedge in IDLE.
  task automatic issue(input logic [15:0] i, output logic d_seen, output logic il_seen,
                       output logic [15:0] b_seen, output logic [7:0] op_seen,
                       output logic cin_seen);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) begin
      compared++; mismatched++;
      $display("FAIL issue_timeout instr=%h ready never rose", i);
    end
    instr = i; instr_valid = 1'b1;
    @(negedge clk);                 // DECODE
    instr_valid = 1'b0;
    @(negedge clk);                 // EXEC
    b_seen = alu_b; op_seen = alu_opcode; cin_seen = alu_cin;
    @(negedge clk);                 // WB
    d_seen = done; il_seen = illegal;
    @(negedge clk);                 // IDLE, write-back visible
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    compared++;
    if (done !== 1'b0 || illegal !== 1'b0) begin
      mismatched++; $display("FAIL reset_pulses got done=%b illegal=%b want 0 0", done, illegal);
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (instr_ready !== 1'b1) begin
      mismatched++; $display("FAIL reset_ready got %b want 1", instr_ready);
    end
    compared++;
    if ({psr, alu_opcode, alu_a, alu_b} !== '0) begin
      mismatched++;
      $display("FAIL reset_outs got psr=%b op=%h a=%h b=%h want all 0", psr, alu_opcode, alu_a, alu_b);
    end
    for (int r = 0; r < 16; r++) begin
      read_reg(r[3:0], v);
      compared++;
      if (v !== 16'h0000) begin
        mismatched++; $display("FAIL reset_reg r%0d got %h want 0000", r, v);
      end
    end
  endtask

  task automatic test_add();
    logic d, il, c; logic [15:0] b, v; logic [7:0] op;
    preload(4'd1, 16'h7FFF); preload(4'd2, 16'h0001);
    issue(16'h0152, d, il, b, op, c);
    compared++;
    if (op !== 8'h05) begin mismatched++; $display("FAIL add_opcode got %h want 05", op); end
    compared++;
    if (d !== 1'b1 || il !== 1'b0) begin
      mismatched++; $display("FAIL add_done got done=%b illegal=%b want 1 0", d, il);
    end
    read_reg(4'd1, v);
    compared++;
    if (v !== 16'h8000) begin mismatched++; $display("FAIL add_r1 got %h want 8000", v); end
    read_reg(4'd2, v);
    compared++;
    if (v !== 16'h0001) begin mismatched++; $display("FAIL add_r2 got %h want 0001", v); end
    compared++;
    if (psr !== 5'b10100) begin mismatched++; $display("FAIL add_psr got %b want 10100", psr); end
  endtask

  task automatic test_addi();
    logic d, il, c; logic [15:0] b, v; logic [7:0] op;
    preload(4'd3, 16'h0001);
    issue(16'h53FF, d, il, b, op, c);
    compared++;
    if (b !== 16'hFFFF) begin mismatched++; $display("FAIL addi_b got %h want ffff", b); end
    compared++;
    if (op !== 8'h5F) begin mismatched++; $display("FAIL addi_opcode got %h want 5f", op); end
    read_reg(4'd3, v);
    compared++;
    if (v !== 16'h0000) begin mismatched++; $display("FAIL addi_r3 got %h want 0000", v); end
    compared++;
    if (psr !== 5'b01000) begin mismatched++; $display("FAIL addi_psr got %b want 01000", psr); end
  endtask

  task automatic test_cmp();
    logic d, il, c; logic [15:0] b, v; logic [7:0] op;
    preload(4'd4, 16'h0003); preload(4'd5, 16'h0005);
    issue(16'h04B5, d, il, b, op, c);
    read_reg(4'd4, v);
    compared++;
    if (v !== 16'h0003) begin mismatched++; $display("FAIL cmp_r4 got %h want 0003", v); end
    compared++;
    if (psr !== 5'b10010) begin mismatched++; $display("FAIL cmp_psr got %b want 10010", psr); end
    compared++;
    if (d !== 1'b1) begin mismatched++; $display("FAIL cmp_done got %b want 1", d); end
  endtask

  task automatic test_illegal_nop();
    logic d, il, c; logic [15:0] b, v; logic [7:0] op;
    issue(16'h010A, d, il, b, op, c);
    compared++;
    if (d !== 1'b1 || il !== 1'b1) begin
      mismatched++; $display("FAIL ill_pulses got done=%b illegal=%b want 1 1", d, il);
    end
    read_reg(4'd1, v);
    compared++;
    if (v !== 16'h8000) begin mismatched++; $display("FAIL ill_r1 got %h want 8000", v); end
    compared++;
    if (psr !== 5'b10010) begin mismatched++; $display("FAIL ill_psr got %b want 10010", psr); end
    issue(16'h0000, d, il, b, op, c);
    compared++;
    if (d !== 1'b1 || il !== 1'b0) begin
      mismatched++; $display("FAIL nop_pulses got done=%b illegal=%b want 1 0", d, il);
    end
    read_reg(4'd0, v);
    compared++;
    if (v !== 16'h0000) begin mismatched++; $display("FAIL nop_r0 got %h want 0000", v); end
    compared++;
    if (psr !== 5'b10010) begin mismatched++; $display("FAIL nop_psr got %b want 10010", psr); end
  endtask

  task automatic test_carry_chain();
    logic d, il, c; logic [15:0] b, v; logic [7:0] op;
    preload(4'd6, 16'hFFFF); preload(4'd7, 16'h0001);
    issue(16'h0657, d, il, b, op, c);
    read_reg(4'd6, v);
    compared++;
    if (v !== 16'h0000) begin mismatched++; $display("FAIL chain_r6 got %h want 0000", v); end
    compared++;
    if (psr !== 5'b01001) begin mismatched++; $display("FAIL chain_psr1 got %b want 01001", psr); end
    preload(4'd8, 16'h0000); preload(4'd9, 16'h0000);
    issue(16'h0879, d, il, b, op, c);
    compared++;
    if (c !== 1'b1) begin mismatched++; $display("FAIL chain_cin got %b want 1", c); end
    read_reg(4'd8, v);
    compared++;
    if (v !== 16'h0001) begin mismatched++; $display("FAIL chain_r8 got %h want 0001", v); end
    compared++;
    if (psr !== 5'b00000) begin mismatched++; $display("FAIL chain_psr2 got %b want 00000", psr); end
  endtask

  task automatic test_imm_forms();
    logic d, il, c; logic [15:0] b; logic [7:0] op;
    issue(16'h6A80, d, il, b, op, c);
    compared++;
    if (b !== 16'h0080 || op !== 8'h68) begin
      mismatched++; $display("FAIL zext_imm got b=%h op=%h want 0080 68", b, op);
    end
    issue(16'h5A80, d, il, b, op, c);
    compared++;
    if (b !== 16'hFF80 || op !== 8'h58) begin
      mismatched++; $display("FAIL sext_imm got b=%h op=%h want ff80 58", b, op);
    end
    issue(16'h8A03, d, il, b, op, c);
    compared++;
    if (b !== 16'h0003 || op !== 8'h80 || il !== 1'b0) begin
      mismatched++; $display("FAIL shift_imm got b=%h op=%h ill=%b want 0003 80 0", b, op, il);
    end
    issue(16'h2A03, d, il, b, op, c);
    compared++;
    if (il !== 1'b1) begin mismatched++; $display("FAIL bad_op_illegal got %b want 1", il); end
  endtask

  task automatic test_reset_abort();
    logic d, il, c; logic [15:0] b, v; logic [7:0] op;
    int dcnt = 0;
    preload(4'd1, 16'h0005); preload(4'd2, 16'h0003);
    @(negedge clk);
    instr = 16'h0152; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);                 // EXEC
    rst_n = 1'b0;
    #1;
    compared++;
    if (psr !== 5'b00000 || done !== 1'b0) begin
      mismatched++; $display("FAIL abort_state got psr=%b done=%b want 00000 0", psr, done);
    end
    read_reg(4'd1, v);
    compared++;
    if (v !== 16'h0000) begin mismatched++; $display("FAIL abort_r1 got %h want 0000", v); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    compared++;
    if (dcnt != 0) begin mismatched++; $display("FAIL abort_done got %0d pulses want 0", dcnt); end
    preload(4'd1, 16'h0002); preload(4'd2, 16'h0003);
    issue(16'h0152, d, il, b, op, c);
    read_reg(4'd1, v);
    compared++;
    if (v !== 16'h0005 || d !== 1'b1) begin
      mismatched++; $display("FAIL abort_next got r1=%h done=%b want 0005 1", v, d);
    end
  endtask

  task automatic test_ld_timing();
    logic [15:0] v; logic dseen;
    preload(4'd10, 16'h0010); preload(4'd11, 16'h0001);
    @(negedge clk);
    instr = 16'h0A5B; instr_valid = 1'b1;
    ld_en = 1'b1; ld_addr = 4'd11; ld_data = 16'h0100;
    @(negedge clk);                 // DECODE: this load must be dropped
    instr_valid = 1'b0;
    ld_addr = 4'd12; ld_data = 16'hBEEF;
    @(negedge clk);                 // EXEC
    ld_en = 1'b0;
    compared++;
    if (alu_b !== 16'h0100) begin mismatched++; $display("FAIL ld_accept_b got %h want 0100", alu_b); end
    @(negedge clk);
    dseen = done;
    @(negedge clk);
    compared++;
    if (dseen !== 1'b1) begin mismatched++; $display("FAIL ld_done got %b want 1", dseen); end
    read_reg(4'd10, v);
    compared++;
    if (v !== 16'h0110) begin mismatched++; $display("FAIL ld_r10 got %h want 0110", v); end
    read_reg(4'd12, v);
    compared++;
    if (v !== 16'h0000) begin mismatched++; $display("FAIL ld_decode_ignored got %h want 0000", v); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    int dcnt = 0, rcnt = 0;
    preload(4'd13, 16'h0000);
    @(negedge clk);
    instr = 16'h5D01; instr_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
      if (instr_ready === 1'b1) rcnt++;
    end
    instr_valid = 1'b0;
    compared++;
    if (dcnt != 2 || rcnt != 2) begin
      mismatched++; $display("FAIL b2b_rate got done=%0d ready=%0d want 2 2", dcnt, rcnt);
    end
    read_reg(4'd13, v);
    compared++;
    if (v !== 16'h0002) begin mismatched++; $display("FAIL b2b_r13 got %h want 0002", v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_cmp();
    test_illegal_nop();
    test_carry_chain();
    test_imm_forms();
    test_reset_abort();
    test_ld_timing();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
